alu_issue_unit: RTL and testbench

Decode/issue stage placed directly upstream of the 8-bit combinational ALU.
- Accepts 16-bit instructions over a valid/ready handshake.
- Decodes the opcode into the 3-bit ALU control code.
- Reads operands from an internal 8x8 register file and drives the ALU inputs.
- Captures the ALU result and writes it back.
- Multi-cycle, one instruction in flight, with a HALT state.

---
 rtl/risc8_pkg.sv | 50 +++++
 rtl/reg_file_8x8.sv | 30 +++
 rtl/alu_issue_unit.sv | 93 +++++++++
 tb/tb_alu_issue_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc8_pkg.sv
// Shared opcodes, instruction layout and FSM encoding for the 8-bit issue
// stage and its register file.
package risc8_pkg;
    localparam int DW    = 8;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Field order mirrors the bit positions above (op in the top bits).
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [3:0] rsvd;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic [DW-1:0] imm_of(input instr_t i);
        logic [15:0] raw;
        raw = i;
        return raw[IMM_MSB:IMM_LSB];
    endfunction
endpackage

// File: rtl/reg_file_8x8.sv
// 8x8 register file: two combinational read ports, a debug read port and one
// synchronous write port. r0 is never written, so it always reads zero.
module reg_file_8x8
    import risc8_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] dbg_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);
    logic [NREGS-1:0][DW-1:0] regs;

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (we && wa != '0)
            regs[wa] <= wd;
    end

    assign rd1      = regs[ra1];
    assign rd2      = regs[ra2];
    assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/alu_issue_unit.sv
// Decode/issue stage for the 8-bit combinational ALU: one instruction in
// flight, IDLE -> READ -> EXEC -> WB, with a terminal HALT state.
module alu_issue_unit
    import risc8_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_ctrl,
    input  logic [DW-1:0] alu_result,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          zero_flag,
    output logic          halted,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);
    state_t        state, nstate;
    instr_t        ir;
    logic [DW-1:0] result_q;
    logic [DW-1:0] rd1, rd2;
    logic          is_alu;

    assign is_alu = (ir.op < OP_LDI);

    reg_file_8x8 u_rf (
        .clk      (clk),
        .rst      (rst),
        .ra1      (ir.rs1),
        .ra2      (ir.rs2),
        .dbg_addr (dbg_addr),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_data (dbg_data),
        .we       (wb_valid),
        .wa       (ir.rd),
        .wd       (result_q)
    );

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE: if (instr_valid) nstate = S_READ;
            S_READ: nstate = S_EXEC;
            S_EXEC: nstate = (ir.op == OP_HALT) ? S_HALT : S_WB;
            S_WB:   nstate = S_IDLE;
            S_HALT: nstate = S_HALT;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ir        <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            result_q  <= '0;
            zero_flag <= 1'b0;
        end else begin
            state <= nstate;
            case (state)
                S_IDLE: if (instr_valid) ir <= instr_t'(instr);
                S_READ: if (is_alu) begin
                    alu_a    <= rd1;
                    alu_b    <= rd2;
                    alu_ctrl <= ir.op;
                end
                S_EXEC: begin
                    if (is_alu)
                        result_q <= alu_result;
                    else if (ir.op == OP_LDI)
                        result_q <= imm_of(ir);
                end
                // LDI commits without touching the flag.
                S_WB: if (is_alu) zero_flag <= (result_q == '0);
                default: ;
            endcase
        end
    end

    assign instr_ready = (state == S_IDLE);
    assign wb_valid    = (state == S_WB);
    assign halted      = (state == S_HALT);
    assign wb_addr     = ir.rd;
    assign wb_data     = result_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed + randomized bench for alu_issue_unit, checked against an
// architectural register/flag model and a behavioural ALU.
module tb_alu_issue_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  alu_a, alu_b, alu_result, wb_data, dbg_data;
    logic [2:0]  alu_ctrl, wb_addr, dbg_addr;
    logic        wb_valid, zero_flag, halted;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] m [8];
    logic       mz;

    alu_issue_unit dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_data(wb_data), .zero_flag(zero_flag),
        .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return {op[2:0], rd[2:0], rs1[2:0], rs2[2:0], 4'b0};
    endfunction

    function automatic logic [15:0] ldi(input int rd, input logic [7:0] imm);
        return {3'b110, rd[2:0], 2'b00, imm};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        mz = 1'b0;
    endtask

    // Architectural effect of one instruction; returns the committed value.
    task automatic model_exec(input logic [15:0] ins, output logic [7:0] res);
        int op, rd;
        op = int'(ins[15:13]);
        rd = int'(ins[12:10]);
        if (op < 6) res = alu_fn(op[2:0], m[ins[9:7]], m[ins[6:4]]);
        else        res = ins[7:0];
        if (op < 6) mz = (res == 8'h00);
        if (rd != 0) m[rd] = res;
    endtask

    // Full handshake of one instruction from IDLE, checking each phase.
    task automatic run_instr(input logic [15:0] ins);
        logic [7:0] a, b, res;
        int op;
        op = int'(ins[15:13]);
        a  = m[ins[9:7]];
        b  = m[ins[6:4]];
        chk("ready_idle", instr_ready, 1);
        instr_valid = 1'b1; instr = ins;
        step();
        instr_valid = 1'b0; instr = 16'($urandom);
        chk("ready_read", instr_ready, 0);
        chk("wb_read", wb_valid, 0);
        step();
        chk("wb_exec", wb_valid, 0);
        if (op < 6) begin
            chk("alu_a", alu_a, a);
            chk("alu_b", alu_b, b);
            chk("alu_ctrl", alu_ctrl, ins[15:13]);
        end
        step();
        if (op == 7) begin
            chk("halted", halted, 1);
            chk("ready_halt", instr_ready, 0);
            chk("wb_halt", wb_valid, 0);
        end else begin
            model_exec(ins, res);
            chk("wb_valid", wb_valid, 1);
            chk("wb_addr", wb_addr, ins[12:10]);
            chk("wb_data", wb_data, res);
            dbg_addr = ins[12:10];
            step();
            chk("wb_after", wb_valid, 0);
            chk("ready_after", instr_ready, 1);
            chk("zero_flag", zero_flag, mz);
            chk("dbg_rd", dbg_data, m[ins[12:10]]);
        end
    endtask

    initial begin
        logic [15:0] q[$];
        int          acc[$];
        logic [7:0]  expd[$];
        logic [2:0]  expa[$];
        logic [7:0]  res;
        int idx, cyc, last_acc;
        logic r;

        rst = 1'b1; instr_valid = 1'b1; instr = ldi(1, 8'hAA); dbg_addr = 3'd1;
        model_reset();
        step(); step();
        chk("rst_ready", instr_ready, 1);
        chk("rst_wb", wb_valid, 0);
        chk("rst_outs", {alu_a, alu_b}, 0);
        chk("rst_misc", {alu_ctrl, wb_addr, zero_flag, halted}, 0);
        chk("rst_dbg", dbg_data, 0);
        rst = 1'b0; instr_valid = 1'b0;

        run_instr(ldi(1, 8'h05));
        run_instr(ldi(2, 8'h03));
        run_instr(enc(0, 3, 1, 2));
        chk("add_r3", m[3], 8'h08);
        run_instr(enc(1, 4, 2, 1));
        chk("sub_wrap", m[4], 8'hFE);
        run_instr(enc(1, 5, 1, 1));
        chk("sub_zero", mz, 1);
        run_instr(ldi(6, 8'h00));

        run_instr(ldi(1, 8'hF0));
        run_instr(ldi(2, 8'h3C));
        run_instr(enc(2, 3, 1, 2));
        run_instr(enc(3, 3, 1, 2));
        run_instr(enc(4, 3, 1, 2));
        run_instr(enc(5, 3, 1, 2));
        run_instr(ldi(4, 8'hFF));
        run_instr(ldi(5, 8'h01));
        run_instr(enc(0, 6, 4, 5));

        // Back-to-back stream with instr_valid held high.
        q = '{ldi(1, 8'h21), ldi(2, 8'h42), enc(0, 0, 1, 2), enc(4, 7, 1, 2),
              ldi(0, 8'h99), enc(1, 3, 7, 2)};
        idx = 0; cyc = 0; last_acc = -1;
        instr_valid = 1'b1; instr = q[0];
        while ((idx < q.size() || expd.size() != 0) && cyc < 100) begin
            r = instr_ready;
            step(); cyc++;
            if (r && instr_valid) begin
                if (last_acc >= 0) chk("accept_gap", 16'(cyc - last_acc), 4);
                last_acc = cyc;
                model_exec(q[idx], res);
                expd.push_back(res);
                expa.push_back(q[idx][12:10]);
                acc.push_back(cyc);
                idx++;
                if (idx < q.size()) instr = q[idx];
                else instr_valid = 1'b0;
            end
            if (wb_valid) begin
                if (expd.size() == 0) chk("wb_spurious", 1, 0);
                else begin
                    chk("stream_addr", wb_addr, expa.pop_front());
                    chk("stream_data", wb_data, expd.pop_front());
                    // WB is the third cycle after the accepting edge.
                    chk("stream_lat", 16'(cyc - acc.pop_front()), 2);
                end
            end
        end
        instr_valid = 1'b0;
        chk("stream_done", 16'(idx), 16'(q.size()));
        chk("stream_drain", 16'(expd.size()), 0);
        step();
        dbg_addr = 3'd0;
        #1 chk("r0_zero", dbg_data, 0);

        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 6);
            if (op == 6) run_instr(ldi($urandom_range(0, 7), 8'($urandom)));
            else run_instr(enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
        end

        // Reset while ADD sits in EXEC: no writeback may follow.
        run_instr(ldi(1, 8'h05));
        run_instr(ldi(2, 8'h03));
        instr_valid = 1'b1; instr = enc(0, 3, 1, 2);
        step();
        instr_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        model_reset();
        chk("mid_rst_wb", wb_valid, 0);
        chk("mid_rst_alu", {alu_a, alu_b}, 0);
        chk("mid_rst_misc", {alu_ctrl, wb_addr, zero_flag, halted}, 0);
        chk("mid_rst_wbdata", wb_data, 0);
        dbg_addr = 3'd1;
        #1 chk("mid_rst_r1", dbg_data, 0);
        dbg_addr = 3'd3;
        #1 chk("mid_rst_r3", dbg_data, 0);
        rst = 1'b0;
        step();
        chk("mid_rst_nowb", wb_valid, 0);
        run_instr(ldi(1, 8'h11));

        run_instr(enc(7, 0, 0, 0));
        instr_valid = 1'b1; instr = ldi(2, 8'h77);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_hold", {halted, instr_ready, wb_valid}, 3'b100);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; instr_valid = 1'b0;
        model_reset();
        chk("halt_clear", halted, 0);
        chk("halt_ready", instr_ready, 1);
        run_instr(ldi(2, 8'h5A));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
